// File: rtl/lfsr_health_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_health_pkg
// Description : Shared types and constants for the LFSR health monitor:
//               FSM state encoding, fail-flag bit positions and default
//               parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_health_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  // Bit positions inside the 3-bit fail-flag vector
  localparam int FAIL_RCT  = 0;
  localparam int FAIL_APT  = 1;
  localparam int FAIL_ZERO = 2;

  localparam int DEF_RCT_CUTOFF = 4;
  localparam int DEF_APT_WINDOW = 64;
  localparam int DEF_APT_CUTOFF = 8;

endpackage
`default_nettype wire

// File: rtl/popcount8.sv
`default_nettype none
// ============================================================================
// Module      : popcount8
// Description : Combinational count of the 1 bits in an 8-bit value.
// Ports       : data  (in, 8)  - value to count
//               count (out, 4) - number of set bits, 0..8
// Revision    : 1.0 - initial release
// ============================================================================
module popcount8 (
  input  logic [7:0] data,
  output logic [3:0] count
);

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'd0, data[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_health_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_health_monitor
// Description : Online health checker for an 8-bit LFSR byte stream. Runs a
//               repetition-count test, an adaptive-proportion test over fixed
//               windows and an all-zero lockup check, accumulates the ones
//               count of each clean window, and latches any failure until
//               clear or reset.
// Ports       : clk, rst_n (async, active-low)
//               sample_valid, sample[7:0]  - input stream
//               clear                      - synchronous soft clear
//               healthy, alarm, rct_fail, apt_fail, zero_fail,
//               window_done, ones_count[OW-1:0], windows_passed[7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_health_monitor
  import lfsr_health_pkg::*;
#(
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF,
  parameter int OW         = $clog2(8*APT_WINDOW+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [7:0]    sample,
  input  logic          clear,
  output logic          healthy,
  output logic          alarm,
  output logic          rct_fail,
  output logic          apt_fail,
  output logic          zero_fail,
  output logic          window_done,
  output logic [OW-1:0] ones_count,
  output logic [7:0]    windows_passed
);

  localparam int IW = (APT_WINDOW > 2) ? $clog2(APT_WINDOW) : 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_CUTOFF + 1);

  localparam logic [IW-1:0] IDX_LAST    = IW'(APT_WINDOW - 1);
  localparam logic [RW-1:0] REP_TRIP    = RW'(RCT_CUTOFF - 1);
  localparam logic [AW-1:0] APT_TRIP    = AW'(APT_CUTOFF - 1);

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [7:0]      last_byte, last_nx;
  logic [RW-1:0]   rep_cnt, rep_nx;
  logic [7:0]      ref_byte, ref_nx;
  logic [AW-1:0]   apt_cnt, apt_nx;
  logic [OW-1:0]   ones_acc, acc_nx;
  logic [2:0]      flags, flags_nx;
  logic [OW-1:0]   oc_nx;
  logic [7:0]      wp_nx;
  logic            wd_nx, healthy_nx, alarm_nx;

  logic            accept;
  logic [2:0]      hits;
  logic [3:0]      pc;

  popcount8 u_popcount8 (
    .data  (sample),
    .count (pc)
  );

  assign accept = sample_valid && !clear && (state != ST_FAIL);

  // Failure checks on the incoming byte. rep_cnt == 0 marks "no previous
  // sample yet", so the very first byte can never trip the RCT.
  always_comb begin
    hits = 3'b000;
    hits[FAIL_RCT]  = (rep_cnt != '0) && (sample == last_byte) && (rep_cnt == REP_TRIP);
    hits[FAIL_APT]  = (idx != '0) && (sample == ref_byte) && (apt_cnt == APT_TRIP);
    hits[FAIL_ZERO] = (sample == 8'h00);
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    last_nx  = last_byte;
    rep_nx   = rep_cnt;
    ref_nx   = ref_byte;
    apt_nx   = apt_cnt;
    acc_nx   = ones_acc;
    flags_nx = flags;
    oc_nx    = ones_count;
    wp_nx    = windows_passed;
    wd_nx    = 1'b0;

    if (clear) begin
      state_nx = ST_IDLE;
      idx_nx   = '0;
      last_nx  = '0;
      rep_nx   = '0;
      ref_nx   = '0;
      apt_nx   = '0;
      acc_nx   = '0;
      flags_nx = '0;
      oc_nx    = '0;
      wp_nx    = '0;
    end else if (accept) begin
      if (hits != 3'b000) begin
        // Failing sample: latch every tripped flag, leave window state as is
        flags_nx = flags | hits;
        state_nx = ST_FAIL;
      end else begin
        state_nx = ST_RUN;
        last_nx  = sample;
        if (rep_cnt == '0 || sample != last_byte) begin
          rep_nx = RW'(1);
        end else begin
          rep_nx = rep_cnt + RW'(1);
        end

        if (idx == '0) begin
          ref_nx = sample;
          apt_nx = AW'(1);
          acc_nx = OW'(pc);
        end else begin
          if (sample == ref_byte) begin
            apt_nx = apt_cnt + AW'(1);
          end
          acc_nx = ones_acc + OW'(pc);
        end

        if (idx == IDX_LAST) begin
          idx_nx = '0;
          oc_nx  = acc_nx;
          wd_nx  = 1'b1;
          if (windows_passed != 8'hFF) begin
            wp_nx = windows_passed + 8'd1;
          end
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
    end

    alarm_nx   = |flags_nx;
    healthy_nx = (state_nx != ST_FAIL) && (wp_nx != 8'd0) && !alarm_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      last_byte      <= '0;
      rep_cnt        <= '0;
      ref_byte       <= '0;
      apt_cnt        <= '0;
      ones_acc       <= '0;
      flags          <= '0;
      ones_count     <= '0;
      windows_passed <= '0;
      window_done    <= 1'b0;
      healthy        <= 1'b0;
      alarm          <= 1'b0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      last_byte      <= last_nx;
      rep_cnt        <= rep_nx;
      ref_byte       <= ref_nx;
      apt_cnt        <= apt_nx;
      ones_acc       <= acc_nx;
      flags          <= flags_nx;
      ones_count     <= oc_nx;
      windows_passed <= wp_nx;
      window_done    <= wd_nx;
      healthy        <= healthy_nx;
      alarm          <= alarm_nx;
    end
  end

  assign rct_fail  = flags[FAIL_RCT];
  assign apt_fail  = flags[FAIL_APT];
  assign zero_fail = flags[FAIL_ZERO];

endmodule
`default_nettype wire

// File: tb/tb_lfsr_health_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_health_monitor
// Description : Directed self-checking bench for lfsr_health_monitor with
//               default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_health_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       clear = 1'b0;
  logic       healthy, alarm, rct_fail, apt_fail, zero_fail, window_done;
  logic [9:0] ones_count;
  logic [7:0] windows_passed;

  int tests_run = 0;
  int tests_failed = 0;
  int wd_pulses = 0;
  int wd_base;

  always #5 clk = ~clk;

  lfsr_health_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .sample         (sample),
    .clear          (clear),
    .healthy        (healthy),
    .alarm          (alarm),
    .rct_fail       (rct_fail),
    .apt_fail       (apt_fail),
    .zero_fail      (zero_fail),
    .window_done    (window_done),
    .ones_count     (ones_count),
    .windows_passed (windows_passed)
  );

  // Outputs are sampled on the falling edge, half a cycle after they update
  always @(negedge clk) if (window_done) wd_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input set for a single rising edge
  task automatic drive(input logic v, input logic c, input logic [7:0] s);
    @(negedge clk);
    sample_valid = v;
    clear        = c;
    sample       = s;
  endtask

  // Drop inputs and move to the falling edge after the last driven edge
  task automatic settle();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"}, {healthy, alarm, rct_fail, apt_fail, zero_fail, window_done}, 32'd0);
    check({tag, ".ones"}, ones_count, 32'd0);
    check({tag, ".wp"},   windows_passed, 32'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.healthy", healthy, 1'b0);
    check("idle.alarm",   alarm,   1'b0);

    // ---------------- clean window 0x01..0x40 ----------------
    wd_base = wd_pulses;
    for (int i = 1; i <= 63; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b1, 1'b0, 8'h40);
    @(negedge clk);  // edge taking sample 64 has now passed
    check("win.wd_before", wd_pulses - wd_base, 32'd0);
    sample_valid = 1'b0;
    check("win.pulse_now", window_done, 1'b1);
    check("win.ones",      ones_count, 32'd193);
    check("win.wp",        windows_passed, 32'd1);
    check("win.healthy",   healthy, 1'b1);
    check("win.alarm",     alarm, 1'b0);
    @(negedge clk);
    check("win.pulse_one", window_done, 1'b0);
    check("win.pulses",    wd_pulses - wd_base, 32'd1);

    // ---------------- RCT ----------------
    repeat (3) drive(1'b1, 1'b0, 8'hA5);
    settle();
    check("rct.3rd", rct_fail, 1'b0);
    drive(1'b1, 1'b0, 8'hA5);
    settle();
    check("rct.fail",    rct_fail, 1'b1);
    check("rct.alarm",   alarm, 1'b1);
    check("rct.healthy", healthy, 1'b0);
    check("rct.others",  {apt_fail, zero_fail}, 32'd0);
    for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'(i + 3));
    settle();
    check("rct.frozen_wp",   windows_passed, 32'd1);
    check("rct.frozen_ones", ones_count, 32'd193);
    check("rct.frozen_zero", zero_fail, 1'b0);

    // ---------------- clear ----------------
    drive(1'b0, 1'b1, 8'h00);
    settle();
    check_all_zero("clr1");

    // ---------------- APT ----------------
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 8'h3C : 8'(8'h11 + i / 2));
    settle();
    check("apt.7th", apt_fail, 1'b0);
    drive(1'b1, 1'b0, 8'h3C);
    settle();
    check("apt.fail",  apt_fail, 1'b1);
    check("apt.rct",   rct_fail, 1'b0);
    check("apt.alarm", alarm, 1'b1);

    // ---------------- zero + clear-wins ----------------
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    settle();
    check("zero.fail",  zero_fail, 1'b1);
    check("zero.alarm", alarm, 1'b1);
    check("zero.apt",   apt_fail, 1'b0);
    drive(1'b1, 1'b1, 8'h00);
    settle();
    check_all_zero("zero.clr");

    // ---------------- mid-window asynchronous reset ----------------
    for (int i = 1; i <= 64; i++) drive(1'b1, 1'b0, 8'(i));
    for (int i = 1; i <= 30; i++) drive(1'b1, 1'b0, 8'(i));
    settle();
    check("mid.wp_pre", windows_passed, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid.async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("mid.post");

    wd_base = wd_pulses;
    for (int i = 1; i <= 63; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      if (i % 3 == 0) drive(1'b0, 1'b0, 8'hFF);
    end
    settle();
    check("mid.wd_63", wd_pulses - wd_base, 32'd0);
    check("mid.wp_63", windows_passed, 32'd0);
    drive(1'b1, 1'b0, 8'h40);
    repeat (4) settle();
    check("mid.pulses",  wd_pulses - wd_base, 32'd1);
    check("mid.ones",    ones_count, 32'd193);
    check("mid.wp",      windows_passed, 32'd1);
    check("mid.healthy", healthy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_health_monitor.md
# lfsr_health_monitor

Online health checker placed directly downstream of the `lfsr` stage. It consumes the 8-bit `lfsr_bits` stream one sample per accepted cycle and runs three checks:
- repetition-count test (RCT)
- adaptive-proportion test (APT) over fixed windows
- all-zero lockup detection

It also accumulates a per-window ones count. A detected failure latches an alarm until `clear` or reset, so the top level can flag a stuck or degenerate generator.

## Interface
Parameters:
- `RCT_CUTOFF`, default 4: number of consecutive identical samples that trips the RCT; legal values ≥ 2.
- `APT_WINDOW`, default 64: samples per APT window; legal values ≥ 2.
- `APT_CUTOFF`, default 8: occurrences of a window's first sample that trip the APT; legal range 2..`APT_WINDOW`.
- `OW`, default `$clog2(8*APT_WINDOW+1)` (10 with defaults): width of `ones_count`.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sample_valid` in 1: `sample` is accepted this cycle.
- `sample` in 8: LFSR output byte.
- `clear` in 1: synchronous soft clear of all state, counters and flags.
- `healthy` out 1: at least one full window has passed and the block is not in FAIL.
- `alarm` out 1: OR of the three latched fail flags.
- `rct_fail` out 1: latched RCT failure.
- `apt_fail` out 1: latched APT failure.
- `zero_fail` out 1: latched all-zero sample.
- `window_done` out 1: one-cycle pulse when a window completes cleanly.
- `ones_count` out OW: count of 1 bits in the last clean window.
- `windows_passed` out 8: count of clean windows, saturating at 255.

## Operation
- Reset value of every output is 0, and the FSM resets to IDLE.
- **States:**
  - IDLE: no window has started.
  - RUN: a window is in progress.
  - FAIL: a failure is latched.
- **Transitions:**
  - IDLE→RUN on the first accepted sample that does not fail.
  - RUN→FAIL on any failing sample.
  - FAIL→IDLE only on `clear` or reset.
  - Any state→IDLE on `clear`.
- **Acceptance:** a sample is accepted when `sample_valid`=1, `clear`=0, and the state is not FAIL.
  - In FAIL, samples are ignored and all counters are frozen.
- **RCT:**
  - `rep_cnt` loads 1 on the first sample and whenever the sample differs from `last`.
  - It increments when the sample equals `last`.
  - `rct_fail` sets when `rep_cnt` would reach `RCT_CUTOFF`.
  - `last` updates on every accepted sample.
- **APT:**
  - At window index 0, `ref` captures the sample and `apt_cnt` loads 1.
  - Later samples in the window that equal `ref` increment `apt_cnt`.
  - `apt_fail` sets when `apt_cnt` would reach `APT_CUTOFF`.
- **Zero check:** an accepted sample equal to 0x00 sets `zero_fail`.
- **Ones accumulator:** `ones_acc` accumulates popcount(sample) over the window. The sample at index 0 loads the accumulator rather than adding to it.
- **Window end:** the sample at index `APT_WINDOW-1` closes the window if it does not fail. On close:
  - `ones_count` ← final accumulator value.
  - `windows_passed` increments (saturating).
  - `window_done` pulses.
  - The index wraps to 0, and the next accepted sample starts a new window with a fresh `ref`.
  - `rep_cnt` and `last` carry across the window boundary.
- **Simultaneous events:**
  - `clear` with `sample_valid`: `clear` wins and the sample is discarded.
  - Several checks failing on one sample: every applicable flag sets.
  - A failure on the last sample of a window: no `window_done`, and `ones_count` and `windows_passed` are unchanged.
- **`healthy`** = (state==RUN or IDLE) && `windows_passed`≠0 && !`alarm`.
  - `clear` resets `windows_passed`, so `healthy` drops after a clear.

## Timing
- All outputs are registered.
- Fail flags, `alarm`, and `healthy` deasserting: the cycle after the offending sample is accepted (1-cycle latency).
- `window_done`, `ones_count`, and `windows_passed`: update the cycle after the closing sample; `window_done` is high for exactly one cycle.
- Back-to-back samples every cycle are supported; the block never applies backpressure.
- `clear`: all outputs read 0 the following cycle.
- `rst_n` low mid-window: outputs go to 0 immediately (asynchronous) and the partial window is discarded.

## Structure
- Package `lfsr_health_pkg`:
  - state enum {IDLE, RUN, FAIL}
  - fail-bit index constants (RCT=0, APT=1, ZERO=2)
  - default parameter constants
- One sub-module, `popcount8`: combinational 8-bit→4-bit ones count, instantiated once.
- Everything else lives in the single `lfsr_health_monitor` module.

## Test plan
- **Reset:** assert `rst_n`=0 for 3 cycles mid-stream → all outputs 0; after release with no samples, `healthy`=0 and `alarm`=0.
- **Clean window:** feed 64 consecutive samples 0x01..0x40 → exactly one `window_done` pulse, the cycle after the 64th sample, with `ones_count`=193, `windows_passed`=1, `healthy`=1, `alarm`=0.
- **RCT:** feed 0xA5 four times consecutively → `rct_fail`=1 and `alarm`=1 the cycle after the 4th sample, `healthy`=0. Further samples leave all counters unchanged until `clear`.
- **APT:** feed 0x3C, 0x11, 0x3C, 0x12, … alternating with distinct non-zero fillers → `apt_fail` sets after the 8th 0x3C (sample index 14); `rct_fail`=0.
- **Zero and clear:**
  - Sample 0x00 → `zero_fail`=1.
  - Then `clear` together with `sample_valid` and sample 0x00 → next cycle all outputs 0, state IDLE, no `zero_fail`.
- **Mid-window reset:** after 30 samples, pulse `rst_n` low → outputs clear. The next 64 valid samples, with gaps of `sample_valid`=0, produce exactly one `window_done`.
